ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Multi-cycle instruction fetch stage; replaces the combinational instruction read at the front of the core.
//  Owns the PC and issues one read at a time to instruction memory over a valid/ready AR/R pair.
//  Hands {inst, pc, fault} to the decode stage over a valid/ready handshake.
//  Accepts PC redirects (branch/jump/trap targets) from the execute stage.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h80000000  first fetch address after reset
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst             in   1     asynchronous, active-low reset
//  imem_arvalid    out  1     read request valid
//  imem_arready    in   1     read request accepted
//  imem_araddr     out  XLEN  read address (= pc)
//  imem_rvalid     in   1     read data valid
//  imem_rready     out  1     fetch ready for read data
//  imem_rdata      in   32    instruction word
//  imem_rresp      in   2     0 = OKAY, nonzero = access error
//  inst_valid      out  1     instruction available to decode
//  inst_ready      in   1     decode accepts instruction
//  inst            out  32    instruction word
//  inst_pc         out  XLEN  PC of inst
//  inst_fault      out  1     1 = fetch error or misaligned target; inst is 0
//  redirect_valid  in   1     load new PC (one-cycle pulse)
//  redirect_pc     in   XLEN  new PC
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, pend=0. Outputs: arvalid=0, araddr=RESET_PC, rready=0, inst_valid=0,
//   inst=0, inst_pc=RESET_PC, inst_fault=0.
//  Outputs are decoded from registered state only; no input->output combinational path.
//  States:
//   IDLE: the first clock after reset release -> REQ.
//   REQ:  arvalid=1, araddr=pc, held stable until arready. On arvalid&arready -> WAIT.
//   WAIT: rready=1. On rvalid:
//    - pend=1 (redirect seen since the request was accepted, incl. this cycle): drop the data,
//      pc<=pend_pc, pend<=0, -> REQ.
//    - else latch inst=rdata, inst_pc=pc. If rresp!=0: inst_fault=1 and inst=0. -> OUT.
//   OUT:  inst_valid=1; inst, inst_pc and inst_fault are stable until the handshake.
//    On inst_valid&inst_ready: pc<=pc+4 (mod 2^XLEN, wraps) -> REQ.
//  Redirect handling; the latest redirect always wins:
//   - In REQ: araddr must not change, so record pend<=1 and pend_pc<=redirect_pc.
//     The request completes and its response is discarded in WAIT.
//   - In WAIT: same recording; a redirect in the same cycle as rvalid also discards that response.
//   - In OUT, with or without a handshake that cycle: the held instruction is dropped, pc<=redirect_pc,
//     inst_valid=0 from the next cycle, -> REQ.
//   - Whenever pc is loaded from a redirect with pc[1:0]!=0: no memory access is issued.
//     Go straight to OUT with inst=0, inst_fault=1, inst_pc=target. A handshake then sets pc<=target+4.
//  Exactly one read outstanding; throughput at best 1 instruction per 3 cycles (REQ, WAIT, OUT).
//  Reset asserted mid-operation: immediate return to reset state. Any in-flight response is ignored;
//   the memory side is reset by the same rst.
// TESTING
//  1. Release rst; memory has 1-cycle arready/rvalid, rdata=0x00000413 -> araddr=0x80000000,
//     inst_valid with inst=0x00000413, inst_pc=0x80000000; next araddr=0x80000004.
//  2. inst_ready=0 for 5 cycles in OUT -> inst_valid, inst and inst_pc constant, no new arvalid;
//     on inst_ready=1 -> fetch from pc+4.
//  3. redirect_pc=0x80000100 while in WAIT, response arrives 2 cycles later -> response dropped,
//     no inst_valid; next araddr=0x80000100.
//  4. Redirect to 0x80000102 while in OUT -> no arvalid; inst_valid=1, inst_fault=1, inst=0,
//     inst_pc=0x80000102.
//  5. rresp=2 on the response -> inst_fault=1, inst=0, inst_pc=request address; after handshake
//     fetch continues at +4.
//  6. rst asserted in WAIT and held 2 cycles -> all outputs at reset values; after release,
//     arvalid rises with araddr=0x80000000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch stage: owns the PC, issues one AR/R read at a time to
// instruction memory and presents {inst, pc, fault} to decode over a valid/ready handshake.
module ifu_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_arvalid,
   input  logic            imem_arready,
   output logic [XLEN-1:0] imem_araddr,
   input  logic            imem_rvalid,
   output logic            imem_rready,
   input  logic [31:0]     imem_rdata,
   input  logic [1:0]      imem_rresp,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_fault,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pend_q, pend_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic [31:0]     inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            fault_q, fault_d;

   logic            load_pc;
   logic [XLEN-1:0] target;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      pc_d      = pc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      fault_d   = fault_q;
      load_pc   = 1'b0;
      target    = redirect_pc;

      case (state_q)
         S_IDLE: begin
            if (redirect_valid) load_pc = 1'b1;
            else                state_d = S_REQ;
         end
         S_REQ: begin
            // araddr must stay stable until accepted, so a redirect is only remembered here
            if (redirect_valid) begin
               pend_d    = 1'b1;
               pend_pc_d = redirect_pc;
            end
            if (imem_arready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (pend_q || redirect_valid) begin
                  load_pc = 1'b1;
                  target  = redirect_valid ? redirect_pc : pend_pc_q;
                  pend_d  = 1'b0;
               end else begin
                  fault_d   = (imem_rresp != 2'b00);
                  inst_d    = (imem_rresp != 2'b00) ? 32'h0 : imem_rdata;
                  inst_pc_d = pc_q;
                  state_d   = S_OUT;
               end
            end else if (redirect_valid) begin
               pend_d    = 1'b1;
               pend_pc_d = redirect_pc;
            end
         end
         S_OUT: begin
            if (redirect_valid) begin
               load_pc = 1'b1;
            end else if (inst_ready) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A misaligned redirect target never reaches memory; it is reported as a faulting instruction.
      if (load_pc) begin
         pc_d = target;
         if (target[1:0] != 2'b00) begin
            state_d   = S_OUT;
            inst_d    = 32'h0;
            inst_pc_d = target;
            fault_d   = 1'b1;
         end else begin
            state_d = S_REQ;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= RESET_PC;
         inst_q    <= 32'h0;
         inst_pc_q <= RESET_PC;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
      end
   end

   assign imem_arvalid = (state_q == S_REQ);
   assign imem_araddr  = pc_q;
   assign imem_rready  = (state_q == S_WAIT);
   assign inst_valid   = (state_q == S_OUT);
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;
   assign inst_fault   = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a small instruction memory model answers AR/R requests; expected
// decode-side results are queued when stimulus is set up and popped when inst_valid appears.
module tb_ifu_fetch;

   localparam logic [31:0] RPC = 32'h8000_0000;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_arvalid, imem_arready = 1'b0;
   logic [31:0] imem_araddr;
   logic        imem_rvalid = 1'b0, imem_rready;
   logic [31:0] imem_rdata = 32'h0;
   logic [1:0]  imem_rresp = 2'b00;
   logic        inst_valid, inst_ready = 1'b0;
   logic [31:0] inst, inst_pc;
   logic        inst_fault;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   int   r_lat = 0;
   logic [1:0] resp_next = 2'b00;

   ifu_fetch #(.XLEN(32), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_arvalid(imem_arvalid), .imem_arready(imem_arready), .imem_araddr(imem_araddr),
      .imem_rvalid(imem_rvalid), .imem_rready(imem_rready), .imem_rdata(imem_rdata),
      .imem_rresp(imem_rresp),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .inst_fault(inst_fault),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0000_0413 ^ {a[23:0], 8'h00};
   endfunction

   // Memory model: accepts a request the cycle it appears, answers r_lat cycles into WAIT.
   initial begin : memory
      logic        pending;
      logic [31:0] addr;
      int          cnt;
      pending = 1'b0;
      addr    = 32'h0;
      cnt     = 0;
      forever begin
         @(negedge clk);
         imem_arready = 1'b0;
         imem_rvalid  = 1'b0;
         if (!rst) begin
            pending = 1'b0;
            cnt     = 0;
         end else if (pending) begin
            if (imem_rready) begin
               if (cnt >= r_lat) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = mem_word(addr);
                  imem_rresp  = resp_next;
                  pending     = 1'b0;
               end else begin
                  cnt++;
               end
            end
         end else if (imem_arvalid) begin
            imem_arready = 1'b1;
            addr         = imem_araddr;
            pending      = 1'b1;
            cnt          = 0;
         end
      end
   end

   task automatic wait_valid(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (inst_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: inst_valid=%b after 50 cycles, required 1", name, inst_valid);
      end
   endtask

   task automatic accept();
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({imem_arvalid, imem_rready, inst_valid, inst_fault} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ctl: arvalid/rready/valid/fault=%b, required 0000",
                  {imem_arvalid, imem_rready, inst_valid, inst_fault});
      end
      n_cmp++;
      if ({imem_araddr, inst, inst_pc} !== {RPC, 32'h0, RPC}) begin
         n_err++;
         $display("FAIL reset_data: araddr=%h inst=%h inst_pc=%h, required %h 0 %h",
                  imem_araddr, inst, inst_pc, RPC, RPC);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (imem_arvalid !== 1'b1 || imem_araddr !== RPC) begin
         n_err++;
         $display("FAIL reset_first_req: arvalid=%b araddr=%h, required 1 %h",
                  imem_arvalid, imem_araddr, RPC);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      exp_q.push_back('{32'h0000_0413, RPC, 1'b0});
      wait_valid("basic");
      e = exp_q.pop_front();
      n_cmp++;
      if ({inst, inst_pc, inst_fault} !== {e.inst, e.pc, e.fault}) begin
         n_err++;
         $display("FAIL basic_inst: got %h/%h/%b, required %h/%h/%b",
                  inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
      end
      accept();
      n_cmp++;
      if (imem_arvalid !== 1'b1 || imem_araddr !== RPC + 32'd4) begin
         n_err++;
         $display("FAIL basic_next_req: arvalid=%b araddr=%h, required 1 %h",
                  imem_arvalid, imem_araddr, RPC + 32'd4);
      end
   endtask

   task automatic test_stall();
      exp_t e;
      exp_q.push_back('{mem_word(RPC + 32'd4), RPC + 32'd4, 1'b0});
      wait_valid("stall");
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({inst_valid, imem_arvalid, inst, inst_pc, inst_fault} !==
             {1'b1, 1'b0, e.inst, e.pc, e.fault}) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: valid=%b arvalid=%b %h/%h/%b, required 1 0 %h/%h/%b",
                     i, inst_valid, imem_arvalid, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
         end
         @(negedge clk);
      end
      accept();
      n_cmp++;
      if (imem_arvalid !== 1'b1 || imem_araddr !== RPC + 32'd8) begin
         n_err++;
         $display("FAIL stall_next_req: arvalid=%b araddr=%h, required 1 %h",
                  imem_arvalid, imem_araddr, RPC + 32'd8);
      end
   endtask

   task automatic test_redirect_wait();
      exp_t e;
      bit   saw_valid = 1'b0;
      bit   saw_req   = 1'b0;
      r_lat = 2;
      @(negedge clk);
      n_cmp++;
      if (imem_rready !== 1'b1) begin
         n_err++;
         $display("FAIL rdw_in_wait: rready=%b, required 1", imem_rready);
      end
      redirect_valid = 1'b1;
      redirect_pc    = RPC + 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0;
      r_lat          = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (inst_valid === 1'b1) saw_valid = 1'b1;
         if (imem_arvalid === 1'b1) begin
            saw_req = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (saw_valid !== 1'b0 || saw_req !== 1'b1) begin
         n_err++;
         $display("FAIL rdw_drop: saw_valid=%b saw_req=%b, required 0 1", saw_valid, saw_req);
      end
      n_cmp++;
      if (imem_araddr !== RPC + 32'h100) begin
         n_err++;
         $display("FAIL rdw_addr: araddr=%h, required %h", imem_araddr, RPC + 32'h100);
      end
      exp_q.push_back('{mem_word(RPC + 32'h100), RPC + 32'h100, 1'b0});
      wait_valid("rdw");
      e = exp_q.pop_front();
      n_cmp++;
      if ({inst, inst_pc, inst_fault} !== {e.inst, e.pc, e.fault}) begin
         n_err++;
         $display("FAIL rdw_inst: got %h/%h/%b, required %h/%h/%b",
                  inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
      end
   endtask

   task automatic test_misaligned();
      exp_t e;
      exp_q.push_back('{32'h0, RPC + 32'h102, 1'b1});
      redirect_valid = 1'b1;
      redirect_pc    = RPC + 32'h102;
      @(negedge clk);
      redirect_valid = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({inst_valid, inst, inst_pc, inst_fault} !== {1'b1, e.inst, e.pc, e.fault}) begin
         n_err++;
         $display("FAIL mis_inst: valid=%b %h/%h/%b, required 1 %h/%h/%b",
                  inst_valid, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
      end
      @(negedge clk);
      n_cmp++;
      if (imem_arvalid !== 1'b0 || inst_valid !== 1'b1) begin
         n_err++;
         $display("FAIL mis_no_req: arvalid=%b valid=%b, required 0 1", imem_arvalid, inst_valid);
      end
      accept();
      n_cmp++;
      if (imem_arvalid !== 1'b1 || imem_araddr !== RPC + 32'h106) begin
         n_err++;
         $display("FAIL mis_next_req: arvalid=%b araddr=%h, required 1 %h",
                  imem_arvalid, imem_araddr, RPC + 32'h106);
      end
      exp_q.push_back('{mem_word(RPC + 32'h106), RPC + 32'h106, 1'b0});
      wait_valid("mis_next");
      e = exp_q.pop_front();
      n_cmp++;
      if ({inst, inst_pc, inst_fault} !== {e.inst, e.pc, e.fault}) begin
         n_err++;
         $display("FAIL mis_next_inst: got %h/%h/%b, required %h/%h/%b",
                  inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
      end
   endtask

   task automatic test_bus_error();
      exp_t e;
      resp_next      = 2'd2;
      redirect_valid = 1'b1;
      redirect_pc    = RPC + 32'h200;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++;
      if ({inst_valid, imem_arvalid} !== 2'b01 || imem_araddr !== RPC + 32'h200) begin
         n_err++;
         $display("FAIL err_redirect_out: valid=%b arvalid=%b araddr=%h, required 0 1 %h",
                  inst_valid, imem_arvalid, imem_araddr, RPC + 32'h200);
      end
      exp_q.push_back('{32'h0, RPC + 32'h200, 1'b1});
      wait_valid("err");
      resp_next = 2'd0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({inst, inst_pc, inst_fault} !== {e.inst, e.pc, e.fault}) begin
         n_err++;
         $display("FAIL err_inst: got %h/%h/%b, required %h/%h/%b",
                  inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
      end
      accept();
      n_cmp++;
      if (imem_arvalid !== 1'b1 || imem_araddr !== RPC + 32'h204) begin
         n_err++;
         $display("FAIL err_next_req: arvalid=%b araddr=%h, required 1 %h",
                  imem_arvalid, imem_araddr, RPC + 32'h204);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      r_lat = 5;
      @(negedge clk);
      n_cmp++;
      if (imem_rready !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_in_wait: rready=%b, required 1", imem_rready);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({imem_arvalid, imem_rready, inst_valid, inst_fault, imem_araddr, inst, inst_pc} !==
             {4'b0000, RPC, 32'h0, RPC}) begin
            n_err++;
            $display("FAIL rstmid_outputs[%0d]: ctl=%b araddr=%h inst=%h inst_pc=%h, required 0000 %h 0 %h",
                     i, {imem_arvalid, imem_rready, inst_valid, inst_fault},
                     imem_araddr, inst, inst_pc, RPC, RPC);
         end
         if (i < 2) @(negedge clk);
      end
      rst   = 1'b1;
      r_lat = 0;
      @(negedge clk);
      n_cmp++;
      if (imem_arvalid !== 1'b1 || imem_araddr !== RPC) begin
         n_err++;
         $display("FAIL rstmid_req: arvalid=%b araddr=%h, required 1 %h",
                  imem_arvalid, imem_araddr, RPC);
      end
      exp_q.push_back('{32'h0000_0413, RPC, 1'b0});
      wait_valid("rstmid");
      e = exp_q.pop_front();
      n_cmp++;
      if ({inst, inst_pc, inst_fault} !== {e.inst, e.pc, e.fault}) begin
         n_err++;
         $display("FAIL rstmid_inst: got %h/%h/%b, required %h/%h/%b",
                  inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
      end
      accept();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_misaligned();
      test_bus_error();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
